// File: rtl/mod_line_fill_responder_pkg.sv
// mod_line_fill_responder_pkg
//   Definitions shared by the L1 instruction/data caches and the line-fill
//   responder. It holds the fill state encoding, the block geometry constants
//   and an address alignment helper.
//   Ports: none (package).

package mod_line_fill_responder_pkg;

    // The four phases of one block fill, in the order a request passes through them.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_REQ = 2'd1,
        FILL    = 2'd2,
        RESP    = 2'd3
    } fill_state_e;

    localparam int BLOCK_BITS = 512;
    localparam int BEATS      = 8;
    localparam int LOG_BEATS  = 3;
    localparam int ADDR_BITS  = 64;

    // Clears the byte-offset bits so the address points at the first byte of its block.
    function automatic logic [ADDR_BITS-1:0] align_block(
        input logic [ADDR_BITS-1:0] addr,
        input int                   log_bytes
    );
        logic [ADDR_BITS-1:0] mask;
        mask = ~((ADDR_BITS'(1) << log_bytes) - ADDR_BITS'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/mod_line_fill_responder_if.sv
// mod_line_fill_responder_if
//   Bundles the cache-side block protocol and the memory-side beat protocol
//   seen by the line-fill responder.
//   Cache side : reqcyc/req/reqtag -> reqack, resp/resptag/respcyc <- respack
//   Memory side: mem_reqcyc/mem_req -> mem_reqack, mem_respcyc/mem_resp -> mem_respack
//   Modports   : slave  = the responder itself
//                master = the environment (cache plus memory) driving the responder

interface mod_line_fill_responder_if
    import mod_line_fill_responder_pkg::*;
#(
    parameter int WORDSIZE   = 64,
    parameter int TAGWIDTH   = 13,
    parameter int BLOCKWIDTH = BLOCK_BITS
) ();

    logic                  reqcyc;
    logic [ADDR_BITS-1:0]  req;
    logic [TAGWIDTH-1:0]   reqtag;
    logic                  reqack;
    logic [BLOCKWIDTH-1:0] resp;
    logic [TAGWIDTH-1:0]   resptag;
    logic                  respcyc;
    logic                  respack;

    logic                  mem_reqcyc;
    logic [ADDR_BITS-1:0]  mem_req;
    logic                  mem_reqack;
    logic                  mem_respcyc;
    logic [WORDSIZE-1:0]   mem_resp;
    logic                  mem_respack;

    modport slave (
        input  reqcyc, req, reqtag, respack,
        input  mem_reqack, mem_respcyc, mem_resp,
        output reqack, resp, resptag, respcyc,
        output mem_reqcyc, mem_req, mem_respack
    );

    modport master (
        output reqcyc, req, reqtag, respack,
        output mem_reqack, mem_respcyc, mem_resp,
        input  reqack, resp, resptag, respcyc,
        input  mem_reqcyc, mem_req, mem_respack
    );

endinterface

// File: rtl/mod_line_fill_responder_assembler.sv
// mod_line_assembler
//   Beat counter plus a block-wide register. Each loaded beat lands in the
//   slot selected by the counter, so the finished block is ordered by beat,
//   with beat 0 in the lowest bits.
//   Ports:
//     clk, reset : clock and asynchronous active-low reset
//     clear      : restart at beat 0 (the block contents are left alone)
//     load       : store beat into the current slot and advance
//     beat       : incoming memory word
//     block      : assembled block
//     done       : high during the load of the final beat

module mod_line_assembler
    import mod_line_fill_responder_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int NBEATS   = BEATS,
    parameter int CNTW     = LOG_BEATS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load,
    input  logic [WORDSIZE-1:0]        beat,
    output logic [WORDSIZE*NBEATS-1:0] block,
    output logic                       done
);

    logic [CNTW-1:0]            cnt_q;
    logic [WORDSIZE*NBEATS-1:0] block_q;

    assign done  = load && (cnt_q == CNTW'(NBEATS - 1));
    assign block = block_q;

    // The counter wraps to 0 on the final beat, so the next fill starts at slot 0
    // even without a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            block_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            block_q[WORDSIZE*cnt_q +: WORDSIZE] <= beat;
            cnt_q <= done ? '0 : cnt_q + CNTW'(1);
        end
    end

endmodule

// File: rtl/mod_line_fill_responder.sv
// mod_line_fill_responder
//   Memory-side responder of the cache block protocol. It accepts one block
//   request at a time, reads the block as a burst of beats over the memory
//   port, and returns the assembled block with the original request tag.
//   Ports:
//     clk   : single clock; all state changes on posedge
//     reset : asynchronous, active-low; clears all state
//     bus   : mod_line_fill_responder_if.slave (cache and memory handshakes)

module mod_line_fill_responder
    import mod_line_fill_responder_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int LOGWIDTH = 6,
    parameter int TAGWIDTH = 13
) (
    input  logic                            clk,
    input  logic                            reset,
    mod_line_fill_responder_if.slave        bus
);

    localparam int BLOCK_W = (1 << LOGWIDTH) * 8;
    localparam int NBEATS  = BLOCK_W / WORDSIZE;
    localparam int CNTW    = $clog2(NBEATS);

    fill_state_e          state, next_state;
    logic                 start;
    logic                 beat_load;
    logic                 beat_last;
    logic                 mem_reqcyc_c;
    logic                 respcyc_c;
    logic                 reqack_q;
    logic [ADDR_BITS-1:0] mem_req_q;
    logic [TAGWIDTH-1:0]  tag_q;
    logic [BLOCK_W-1:0]   block;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Each phase waits on exactly one handshake, so a
    // request arriving outside IDLE is simply not looked at.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.reqcyc)     next_state = MEM_REQ;
            MEM_REQ: if (bus.mem_reqack) next_state = FILL;
            FILL:    if (beat_last)      next_state = RESP;
            RESP:    if (bus.respack)    next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state. Beats are accepted only in FILL; a beat
    // that shows up together with mem_reqack is still in MEM_REQ and is ignored.
    always_comb begin
        start        = 1'b0;
        beat_load    = 1'b0;
        mem_reqcyc_c = 1'b0;
        respcyc_c    = 1'b0;
        case (state)
            IDLE:    start        = bus.reqcyc;
            MEM_REQ: mem_reqcyc_c = 1'b1;
            FILL:    beat_load    = bus.mem_respcyc;
            RESP:    respcyc_c    = 1'b1;
            default: ;
        endcase
    end

    // Request capture. reqack is a registered copy of the accept decision, so it
    // pulses for one cycle in the first MEM_REQ cycle. The address and tag stay
    // put until the next accepted request. That keeps mem_req stable while memory
    // stalls and keeps resptag stable while the cache stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reqack_q  <= 1'b0;
            mem_req_q <= '0;
            tag_q     <= '0;
        end else begin
            reqack_q <= start;
            if (start) begin
                mem_req_q <= align_block(bus.req, LOGWIDTH);
                tag_q     <= bus.reqtag;
            end
        end
    end

    mod_line_assembler #(
        .WORDSIZE (WORDSIZE),
        .NBEATS   (NBEATS),
        .CNTW     (CNTW)
    ) u_assembler (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .load  (beat_load),
        .beat  (bus.mem_resp),
        .block (block),
        .done  (beat_last)
    );

    assign bus.reqack      = reqack_q;
    assign bus.mem_reqcyc  = mem_reqcyc_c;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_respack = beat_load;
    assign bus.respcyc     = respcyc_c;
    assign bus.resp        = block;
    assign bus.resptag     = tag_q;

endmodule

// File: tb/tb_mod_line_fill_responder.sv
// tb_mod_line_fill_responder
//   Directed bench for the line-fill responder. The bench plays the cache and
//   the memory through the interface master side, and checks every handshake
//   and data value against hand-computed constants.
//   Ports: none (top-level bench).

module tb_mod_line_fill_responder;
    import mod_line_fill_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_compared     = 0;
    int   n_mismatched   = 0;
    int   respack_pulses = 0;
    int   pulse_base;

    logic [511:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_g, blk_h, blk_i;

    mod_line_fill_responder_if #(.WORDSIZE(64), .TAGWIDTH(13), .BLOCKWIDTH(512)) bus ();

    mod_line_fill_responder #(
        .WORDSIZE (64),
        .LOGWIDTH (6),
        .TAGWIDTH (13)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Counts accepted memory beats, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_respack === 1'b1) respack_pulses++;
    end

    // Keeps a broken design from hanging the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_block(input logic [7:0] marker);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[64*i +: 64] = {marker, 48'h0, 8'(i + 1)};
        return b;
    endfunction

    // Runs one request from acceptance through the fill. Memory acknowledges
    // after ack_delay extra cycles and inserts gap idle cycles before each beat.
    // Stray beats are offered in MEM_REQ and must be refused. With n_beats==8
    // the response is checked as well; it is left pending for the caller.
    task automatic apply_stimulus(input logic [63:0] addr, input logic [12:0] tag,
                                  input logic [63:0] exp_mem_req, input logic [511:0] blk,
                                  input int ack_delay, input int gap, input int n_beats);
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        step();
        check_output("reqack_pulse", bus.reqack, 1'b1);
        check_output("mem_reqcyc_set", bus.mem_reqcyc, 1'b1);
        check_output("mem_req_aligned", bus.mem_req, exp_mem_req);
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        for (int d = 0; d < ack_delay; d++) begin
            bus.mem_respcyc = 1'b1;
            bus.mem_resp    = 64'hDEAD_BEEF_0BAD_0BAD;
            #1;
            check_output("no_respack_in_mem_req", bus.mem_respack, 1'b0);
            step();
            check_output("mem_reqcyc_held", bus.mem_reqcyc, 1'b1);
            check_output("mem_req_stable", bus.mem_req, exp_mem_req);
            check_output("reqack_single", bus.reqack, 1'b0);
        end
        bus.mem_reqack  = 1'b1;
        bus.mem_respcyc = 1'b1;
        bus.mem_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check_output("no_respack_with_reqack", bus.mem_respack, 1'b0);
        step();
        bus.mem_reqack  = 1'b0;
        bus.mem_respcyc = 1'b0;
        check_output("mem_reqcyc_drop", bus.mem_reqcyc, 1'b0);
        check_output("reqack_single", bus.reqack, 1'b0);
        for (int i = 0; i < n_beats; i++) begin
            for (int g = 0; g < gap; g++) step();
            bus.mem_respcyc = 1'b1;
            bus.mem_resp    = blk[64*i +: 64];
            #1;
            check_output("mem_respack_beat", bus.mem_respack, 1'b1);
            check_output("respcyc_low_in_fill", bus.respcyc, 1'b0);
            step();
            bus.mem_respcyc = 1'b0;
        end
        if (n_beats == 8) begin
            check_output("respcyc_set", bus.respcyc, 1'b1);
            check_output("resp_block", bus.resp, blk);
            check_output("resptag", bus.resptag, tag);
        end
    endtask

    task automatic accept_response();
        bus.respack = 1'b1;
        step();
        bus.respack = 1'b0;
        check_output("respcyc_drop", bus.respcyc, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_reqack", bus.reqack, 1'b0);
        check_output("rst_respcyc", bus.respcyc, 1'b0);
        check_output("rst_mem_reqcyc", bus.mem_reqcyc, 1'b0);
        check_output("rst_resp", bus.resp, 512'h0);
        check_output("rst_resptag", bus.resptag, 13'h0);
        check_output("rst_mem_req", bus.mem_req, 64'h0);
        check_output("rst_mem_respack", bus.mem_respack, 1'b0);
    endtask

    initial begin
        reset           = 1'b0;
        bus.reqcyc      = 1'b0;
        bus.req         = '0;
        bus.reqtag      = '0;
        bus.respack     = 1'b0;
        bus.mem_reqack  = 1'b0;
        bus.mem_respcyc = 1'b1;
        bus.mem_resp    = 64'h1234;
        for (int i = 0; i < 8; i++) blk_a[64*i +: 64] = 64'h11 * (i + 1);
        blk_b = make_block(8'hB0);
        blk_c = make_block(8'hC0);
        blk_d = make_block(8'hD0);
        blk_e = make_block(8'hE0);
        blk_f = make_block(8'hF0);
        blk_g = make_block(8'h60);
        blk_h = make_block(8'h70);
        blk_i = make_block(8'h80);

        // Reset state, with a stray beat present that must not be accepted.
        step();
        step();
        check_reset_outputs();
        bus.mem_respcyc = 1'b0;
        reset = 1'b1;
        step();

        // Zero-wait memory: reqack at cycle 1, beats at cycles 2..9, response at cycle 10.
        apply_stimulus(64'h0000_0000_4000_1234, 13'h0005, 64'h0000_0000_4000_1200, blk_a, 0, 0, 8);
        check_output("t1_resp_beat0", bus.resp[63:0], 64'h11);
        check_output("t1_resp_beat7", bus.resp[511:448], 64'h88);
        accept_response();

        // Slow memory acknowledge and gaps between beats.
        pulse_base = respack_pulses;
        apply_stimulus(64'h0000_0001_2345_67FF, 13'h0ABC, 64'h0000_0001_2345_67C0, blk_b, 4, 1, 8);
        check_output("t2_respack_pulses", 32'(respack_pulses - pulse_base), 32'd8);
        accept_response();

        // The cache stalls the response while a second request is already waiting.
        apply_stimulus(64'h0000_0000_8000_0040, 13'h1234, 64'h0000_0000_8000_0040, blk_c, 1, 0, 8);
        bus.reqcyc = 1'b1;
        bus.req    = 64'h0000_0000_0000_0FC1;
        bus.reqtag = 13'h0777;
        for (int k = 0; k < 5; k++) begin
            step();
            check_output("t3_respcyc_held", bus.respcyc, 1'b1);
            check_output("t3_resp_stable", bus.resp, blk_c);
            check_output("t3_resptag_stable", bus.resptag, 13'h1234);
            check_output("t3_no_reqack", bus.reqack, 1'b0);
        end
        bus.respack = 1'b1;
        step();
        bus.respack = 1'b0;
        check_output("t3_respcyc_drop", bus.respcyc, 1'b0);
        check_output("t3_no_reqack_on_return", bus.reqack, 1'b0);
        apply_stimulus(64'h0000_0000_0000_0FC1, 13'h0777, 64'h0000_0000_0000_0FC0, blk_d, 0, 0, 8);
        accept_response();

        // A stray beat while idle is refused and does not disturb the block or the counter.
        bus.mem_respcyc = 1'b1;
        bus.mem_resp    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check_output("t4_no_respack_idle", bus.mem_respack, 1'b0);
        step();
        bus.mem_respcyc = 1'b0;
        check_output("t4_resp_untouched", bus.resp, blk_d);
        apply_stimulus(64'h0000_0000_0000_0100, 13'h0042, 64'h0000_0000_0000_0100, blk_e, 2, 0, 8);
        accept_response();

        // Reset in the middle of a fill, after four beats.
        apply_stimulus(64'h0000_0000_0000_1000, 13'h0055, 64'h0000_0000_0000_1000, blk_f, 0, 0, 4);
        bus.mem_respcyc = 1'b1;
        bus.mem_resp    = 64'h5555_5555_5555_5555;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        bus.mem_respcyc = 1'b0;
        #2;
        reset = 1'b1;
        step();
        check_output("t5_no_resp_after_reset", bus.respcyc, 1'b0);
        apply_stimulus(64'h0000_0000_2000_0008, 13'h0066, 64'h0000_0000_2000_0000, blk_g, 0, 0, 8);
        accept_response();

        // Back-to-back requests with extreme tags.
        apply_stimulus(64'h0000_0000_0000_3000, 13'h1FFF, 64'h0000_0000_0000_3000, blk_h, 0, 0, 8);
        accept_response();
        apply_stimulus(64'h0000_0000_0000_3040, 13'h0000, 64'h0000_0000_0000_3040, blk_i, 0, 0, 8);
        accept_response();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
